// File: rtl/fu_scoreboard.sv
// Functional-unit availability table: per-FU busy/countdown/variable-latency state,
// registered ready/done/error outputs. Define FU_UTIL_COUNT_EN to add per-FU busy-cycle counters.
module fu_scoreboard #(
  parameter int NUM_FU = 4,
  parameter int IDX_W  = 2,
  parameter int LAT_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              issue_valid,
  input  logic [IDX_W-1:0]  issue_fu,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic [NUM_FU-1:0] fu_release,
  output logic [NUM_FU-1:0] fu_ready,
  output logic [NUM_FU-1:0] fu_done,
  output logic              any_ready,
  output logic [IDX_W-1:0]  first_ready,
  output logic              issue_err
`ifdef FU_UTIL_COUNT_EN
  ,
  output logic [NUM_FU*16-1:0] util_cnt
`endif
);

  logic [NUM_FU-1:0] busy_vec;
  logic [NUM_FU-1:0] done_vec;
  logic [NUM_FU-1:0] issue_sel;
  logic              issue_accept;
  logic              issue_reject;
  logic              issue_err_reg;
  logic [IDX_W-1:0]  first_next;

  // Out-of-range indices match no select bit, so they fall into the reject path.
  assign issue_accept = issue_valid & ~flush & (|(issue_sel & ~busy_vec));
  assign issue_reject = issue_valid & ~flush & ~issue_accept;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FU; gi++) begin : g_fu
      logic             busy_reg, busy_next;
      logic [LAT_W-1:0] cnt_reg, cnt_next;
      logic             var_reg, var_next;
      logic             done_reg, done_next;

      assign issue_sel[gi] = (issue_fu == IDX_W'(gi));

      always_comb begin
        busy_next = busy_reg;
        cnt_next  = cnt_reg;
        var_next  = var_reg;
        done_next = 1'b0;
        if (flush) begin
          busy_next = 1'b0;
          cnt_next  = '0;
          var_next  = 1'b0;
        end else if (busy_reg) begin
          if (var_reg) begin
            if (fu_release[gi]) begin
              busy_next = 1'b0;
              var_next  = 1'b0;
              done_next = 1'b1;
            end
          end else if (cnt_reg == LAT_W'(1)) begin
            busy_next = 1'b0;
            cnt_next  = '0;
            done_next = 1'b1;
          end else if (cnt_reg != '0) begin
            cnt_next = cnt_reg - LAT_W'(1);
          end
        end else if (issue_accept && issue_sel[gi]) begin
          busy_next = 1'b1;
          cnt_next  = issue_lat;
          var_next  = (issue_lat == '0);
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          busy_reg <= 1'b0;
          cnt_reg  <= '0;
          var_reg  <= 1'b0;
          done_reg <= 1'b0;
        end else begin
          busy_reg <= busy_next;
          cnt_reg  <= cnt_next;
          var_reg  <= var_next;
          done_reg <= done_next;
        end
      end

      assign busy_vec[gi] = busy_reg;
      assign done_vec[gi] = done_reg;

`ifdef FU_UTIL_COUNT_EN
      logic [15:0] util_reg;

      // Saturating busy-cycle counter; survives flush, cleared only by rst.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          util_reg <= '0;
        end else if (busy_reg && (util_reg != 16'hFFFF)) begin
          util_reg <= util_reg + 16'd1;
        end
      end

      assign util_cnt[gi*16 +: 16] = util_reg;
`endif
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_err_reg <= 1'b0;
    end else begin
      issue_err_reg <= issue_reject;
    end
  end

  // Lowest-index free unit; scanning downward lets the smallest index win.
  always_comb begin
    first_next = '0;
    for (int i = NUM_FU - 1; i >= 0; i--) begin
      if (!busy_vec[i]) begin
        first_next = IDX_W'(i);
      end
    end
  end

  assign fu_ready    = ~busy_vec;
  assign fu_done     = done_vec;
  assign any_ready   = |(~busy_vec);
  assign first_ready = first_next;
  assign issue_err   = issue_err_reg;

endmodule

// File: tb/tb_fu_scoreboard.sv
// Bench for fu_scoreboard: cycle-level behavioural model with per-cycle compare,
// plus literal checks from the test plan. Define FU_UTIL_COUNT_EN to also check util_cnt.
module tb_fu_scoreboard;

  localparam int NUM_FU = 4;
  localparam int IDX_W  = 2;
  localparam int LAT_W  = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              issue_valid;
  logic [IDX_W-1:0]  issue_fu;
  logic [LAT_W-1:0]  issue_lat;
  logic [NUM_FU-1:0] fu_release;
  logic [NUM_FU-1:0] fu_ready;
  logic [NUM_FU-1:0] fu_done;
  logic              any_ready;
  logic [IDX_W-1:0]  first_ready;
  logic              issue_err;
`ifdef FU_UTIL_COUNT_EN
  logic [NUM_FU*16-1:0] util_cnt;
`endif

  fu_scoreboard #(.NUM_FU(NUM_FU), .IDX_W(IDX_W), .LAT_W(LAT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .issue_valid (issue_valid),
    .issue_fu    (issue_fu),
    .issue_lat   (issue_lat),
    .fu_release  (fu_release),
    .fu_ready    (fu_ready),
    .fu_done     (fu_done),
    .any_ready   (any_ready),
    .first_ready (first_ready),
    .issue_err   (issue_err)
`ifdef FU_UTIL_COUNT_EN
    ,
    .util_cnt    (util_cnt)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each FU is either free, counting down cycles_left, or waiting for release.
  int         cycles_left [NUM_FU];
  bit         waiting     [NUM_FU];
  logic [3:0] m_done;
  logic       m_err;
  bit   [3:0] busy_before;

  function automatic logic [3:0] m_ready();
    logic [3:0] r;
    for (int i = 0; i < NUM_FU; i++) r[i] = !(cycles_left[i] > 0 || waiting[i]);
    return r;
  endfunction

  function automatic logic [1:0] m_first();
    logic [3:0] r;
    r = m_ready();
    for (int i = 0; i < NUM_FU; i++) if (r[i]) return 2'(i);
    return 2'd0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        cycles_left[i] = 0;
        waiting[i] = 1'b0;
      end
      m_done = '0;
      m_err  = 1'b0;
    end else begin
      busy_before = ~m_ready();
      m_done = '0;
      m_err  = 1'b0;
      if (flush) begin
        for (int i = 0; i < NUM_FU; i++) begin
          cycles_left[i] = 0;
          waiting[i] = 1'b0;
        end
      end else begin
        for (int i = 0; i < NUM_FU; i++) begin
          if (waiting[i] && fu_release[i]) begin
            waiting[i] = 1'b0;
            m_done[i] = 1'b1;
          end else if (cycles_left[i] > 0) begin
            cycles_left[i]--;
            if (cycles_left[i] == 0) m_done[i] = 1'b1;
          end
        end
        if (issue_valid) begin
          if (int'(issue_fu) < NUM_FU && !busy_before[issue_fu]) begin
            if (issue_lat == 0) waiting[issue_fu] = 1'b1;
            else cycles_left[issue_fu] = int'(issue_lat);
          end else begin
            m_err = 1'b1;
          end
        end
      end
    end
  end

  // Per-cycle compare on the falling edge.
  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      chk("fu_ready", 32'(fu_ready), 32'(m_ready()));
      chk("fu_done", 32'(fu_done), 32'(m_done));
      chk("any_ready", 32'(any_ready), 32'(|m_ready()));
      chk("first_ready", 32'(first_ready), 32'(m_first()));
      chk("issue_err", 32'(issue_err), 32'(m_err));
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the edge that consumed them.
  task automatic cyc(input logic v, input logic [1:0] fu, input logic [2:0] lat,
                     input logic [3:0] rel, input logic fl);
    issue_valid = v;
    issue_fu    = fu;
    issue_lat   = lat;
    fu_release  = rel;
    flush       = fl;
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    issue_fu    = '0;
    issue_lat   = '0;
    fu_release  = '0;
    flush       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 2'd0, 3'd0, 4'b0000, 1'b0);
  endtask

  typedef struct packed {
    logic       v;
    logic [1:0] fu;
    logic [2:0] lat;
    logic [3:0] rel;
    logic       fl;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl = '{
      '{1'b1, 2'd0, 3'd2, 4'b0000, 1'b0},
      '{1'b1, 2'd1, 3'd4, 4'b0000, 1'b0},
      '{1'b1, 2'd0, 3'd2, 4'b0000, 1'b0},
      '{1'b1, 2'd2, 3'd0, 4'b0000, 1'b0},
      '{1'b1, 2'd3, 3'd1, 4'b0000, 1'b0},
      '{1'b0, 2'd0, 3'd0, 4'b0100, 1'b0},
      '{1'b1, 2'd2, 3'd0, 4'b0100, 1'b0},
      '{1'b1, 2'd1, 3'd0, 4'b0000, 1'b0},
      '{1'b0, 2'd0, 3'd0, 4'b0110, 1'b0},
      '{1'b1, 2'd3, 3'd7, 4'b1000, 1'b0},
      '{1'b0, 2'd0, 3'd0, 4'b0000, 1'b0},
      '{1'b0, 2'd0, 3'd0, 4'b0000, 1'b1}
    };

    rst = 1'b1;
    flush = 1'b0;
    issue_valid = 1'b0;
    issue_fu = '0;
    issue_lat = '0;
    fu_release = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    cmp_en = 1'b1;

    chk("reset fu_ready", 32'(fu_ready), 32'h0000000F);
    chk("reset any_ready", 32'(any_ready), 32'd1);
    chk("reset first_ready", 32'(first_ready), 32'd0);
    chk("reset fu_done", 32'(fu_done), 32'd0);
    chk("reset issue_err", 32'(issue_err), 32'd0);

    // Fixed latency 3 on FU1
    cyc(1'b1, 2'd1, 3'd3, 4'b0000, 1'b0);
    chk("lat3 busy c1", 32'(fu_ready), 32'h0000000D);
    chk("lat3 first_ready", 32'(first_ready), 32'd0);
    idle(1);
    chk("lat3 busy c2", 32'(fu_ready), 32'h0000000D);
    cyc(1'b0, 2'd0, 3'd0, 4'b0010, 1'b0);
    chk("lat3 busy c3 rel ignored", 32'(fu_ready), 32'h0000000D);
    chk("lat3 no early done", 32'(fu_done), 32'd0);
    idle(1);
    chk("lat3 free c4", 32'(fu_ready), 32'h0000000F);
    chk("lat3 done c4", 32'(fu_done), 32'h00000002);
    idle(1);
    chk("lat3 done clears", 32'(fu_done), 32'd0);

    // Variable latency on FU2, stray release on free FU3
    cyc(1'b1, 2'd2, 3'd0, 4'b0000, 1'b0);
    chk("var busy", 32'(fu_ready), 32'h0000000B);
    idle(2);
    cyc(1'b0, 2'd0, 3'd0, 4'b1000, 1'b0);
    chk("rel free FU3 no done", 32'(fu_done), 32'd0);
    chk("rel free FU3 ready", 32'(fu_ready), 32'h0000000B);
    idle(2);
    chk("var still busy", 32'(fu_ready), 32'h0000000B);
    cyc(1'b0, 2'd0, 3'd0, 4'b0100, 1'b0);
    chk("var released", 32'(fu_ready), 32'h0000000F);
    chk("var done", 32'(fu_done), 32'h00000004);

    // Back-to-back issue into FU0 with lat=1
    cyc(1'b1, 2'd0, 3'd1, 4'b0000, 1'b0);
    chk("fu0 busy", 32'(fu_ready), 32'h0000000E);
    chk("fu0 busy first_ready", 32'(first_ready), 32'd1);
    cyc(1'b1, 2'd0, 3'd1, 4'b0000, 1'b0);
    chk("fu0 reissue err", 32'(issue_err), 32'd1);
    chk("fu0 freed", 32'(fu_ready), 32'h0000000F);
    chk("fu0 done", 32'(fu_done), 32'h00000001);
    cyc(1'b1, 2'd0, 3'd1, 4'b0000, 1'b0);
    chk("fu0 after done accepted", 32'(fu_ready), 32'h0000000E);
    chk("fu0 after done no err", 32'(issue_err), 32'd0);
    idle(1);

    // Flush with same-cycle issue and release
    cyc(1'b1, 2'd0, 3'd7, 4'b0000, 1'b0);
    cyc(1'b1, 2'd1, 3'd0, 4'b0000, 1'b0);
    cyc(1'b1, 2'd2, 3'd5, 4'b0000, 1'b0);
    chk("pre-flush busy", 32'(fu_ready), 32'h00000008);
    chk("pre-flush first_ready", 32'(first_ready), 32'd3);
    cyc(1'b1, 2'd3, 3'd2, 4'b0010, 1'b1);
    chk("flush ready", 32'(fu_ready), 32'h0000000F);
    chk("flush no done", 32'(fu_done), 32'd0);
    chk("flush no err", 32'(issue_err), 32'd0);
    idle(1);
    chk("flush FU3 idle", 32'(fu_ready), 32'h0000000F);

    for (int i = 0; i < 12; i++) cyc(tbl[i].v, tbl[i].fu, tbl[i].lat, tbl[i].rel, tbl[i].fl);
    idle(2);

    // Asynchronous reset during a lat=7 countdown
    cyc(1'b1, 2'd3, 3'd7, 4'b0000, 1'b0);
    idle(2);
    chk("pre-rst busy", 32'(fu_ready), 32'h00000007);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst ready", 32'(fu_ready), 32'h0000000F);
    chk("async rst any_ready", 32'(any_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;

`ifdef FU_UTIL_COUNT_EN
    chk("util FU3 after rst", 32'(util_cnt[63:48]), 32'd0);
    cyc(1'b1, 2'd3, 3'd7, 4'b0000, 1'b0);
    idle(7);
    chk("util FU3 after lat7", 32'(util_cnt[63:48]), 32'd7);
    chk("util FU0 idle", 32'(util_cnt[15:0]), 32'd0);
    idle(1);
    chk("util FU3 holds", 32'(util_cnt[63:48]), 32'd7);
`endif

    idle(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
